store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/sb_ifc.sv | 11 +
 rtl/sb_fwd_select.sv | 30 +++
 rtl/store_buffer.sv | 108 ++++++++++
 tb/tb_store_buffer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: data-path widths and the store-buffer entry record.
// Entries hold word-aligned stores; forwarding compares word addresses only.
package mips_core_pkg;
    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } sb_entry_t;

    function automatic logic sb_word_match(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [ADDR_WIDTH-1:0] b);
        return a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2];
    endfunction
endpackage

// File: rtl/sb_ifc.sv
// Store-buffer forwarding result seen by the load path.
// The buffer drives the out modport; the consumer uses in.
interface sb_ifc;
    import mips_core_pkg::*;
    logic                  sb_hit;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;

    modport out (output sb_hit, valid, data);
    modport in  (input  sb_hit, valid, data);
endinterface

// File: rtl/sb_fwd_select.sv
// Combinational youngest-match select over the buffer entries.
// Scans oldest to youngest starting at head, so the last match seen wins.
module sb_fwd_select
    import mips_core_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t             entries_i [DEPTH],
    input  logic [PTR_W-1:0]      head_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            // Unoccupied slots have valid cleared, so stale contents never match.
            if (entries_i[idx].valid && sb_word_match(entries_i[idx].addr, addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between MEM and the d-cache with store-to-load forwarding.
// Enqueue is refused while full (no same-cycle bypass); head drains on drain_ready.
module store_buffer
    import mips_core_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_valid,
    input  logic [ADDR_WIDTH-1:0] enq_addr,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  enq_ready,
    input  logic                  lu_valid,
    input  logic [ADDR_WIDTH-1:0] lu_addr,
    sb_ifc.out                    sb,
    output logic                  drain_valid,
    output logic [ADDR_WIDTH-1:0] drain_addr,
    output logic [DATA_WIDTH-1:0] drain_data,
    input  logic                  drain_ready,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    sb_entry_t             entries [DEPTH];
    logic                  enq_fire, drain_fire;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign enq_ready   = !full;
    assign drain_valid = !empty;
    assign drain_addr  = addr_mem_q[head_q];
    assign drain_data  = data_mem_q[head_q];
    assign enq_fire    = enq_valid && enq_ready;
    assign drain_fire  = drain_valid && drain_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (drain_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        // Head and tail only coincide when empty or full, so these never collide.
        if (enq_fire) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({enq_fire, drain_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage is left unreset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            addr_mem_q[tail_q] <= enq_addr;
            data_mem_q[tail_q] <= enq_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid = valid_q[i];
            entries[i].addr  = addr_mem_q[i];
            entries[i].data  = data_mem_q[i];
        end
    end

    sb_fwd_select #(.DEPTH(DEPTH)) u_fwd (
        .entries_i (entries),
        .head_i    (head_q),
        .addr_i    (lu_addr),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );

    assign sb.valid  = lu_valid;
    assign sb.sb_hit = lu_valid && fwd_hit;
    assign sb.data   = (lu_valid && fwd_hit) ? fwd_data : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model.
module tb_store_buffer;
    import mips_core_pkg::*;

    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enq_valid;
    logic [ADDR_WIDTH-1:0] enq_addr;
    logic [DATA_WIDTH-1:0] enq_data;
    logic                  enq_ready;
    logic                  lu_valid;
    logic [ADDR_WIDTH-1:0] lu_addr;
    logic                  drain_valid;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [DATA_WIDTH-1:0] drain_data;
    logic                  drain_ready;
    logic                  full;
    logic                  empty;

    sb_ifc sb_if ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid   (enq_valid),
        .enq_addr    (enq_addr),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .lu_valid    (lu_valid),
        .lu_addr     (lu_addr),
        .sb          (sb_if),
        .drain_valid (drain_valid),
        .drain_addr  (drain_addr),
        .drain_data  (drain_data),
        .drain_ready (drain_ready),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t mq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending store with the same word address, if any.
    function automatic bit model_lookup(input logic [31:0] a, output logic [31:0] d);
        d = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr[31:2] == a[31:2]) begin
                d = mq[i].data;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            bit ef, df;
            ef = enq_valid && (mq.size() < DEPTH);
            df = drain_ready && (mq.size() > 0);
            if (df) void'(mq.pop_front());
            if (ef) mq.push_back('{enq_addr, enq_data});
        end
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        bit          eh;
        eh = model_lookup(lu_addr, ed);
        chk("enq_ready",   32'(enq_ready),   32'(mq.size() < DEPTH));
        chk("full",        32'(full),        32'(mq.size() == DEPTH));
        chk("empty",       32'(empty),       32'(mq.size() == 0));
        chk("drain_valid", 32'(drain_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("drain_addr", drain_addr, mq[0].addr);
            chk("drain_data", drain_data, mq[0].data);
        end
        chk("sb_valid", 32'(sb_if.valid),  32'(lu_valid));
        chk("sb_hit",   32'(sb_if.sb_hit), 32'(lu_valid && eh));
        chk("sb_data",  sb_if.data,        (lu_valid && eh) ? ed : 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid   = 1'b0;
        drain_ready = 1'b0;
        lu_valid    = 1'b0;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        enq_addr = '0; enq_data = '0; lu_addr = '0;
        idle();
        lu_valid = 1'b1;
        lu_addr  = 32'h100;
        #3;
        chk("rst_enq_ready",   32'(enq_ready),    32'd1);
        chk("rst_full",        32'(full),         32'd0);
        chk("rst_empty",       32'(empty),        32'd1);
        chk("rst_drain_valid", 32'(drain_valid),  32'd0);
        chk("rst_sb_hit",      32'(sb_if.sb_hit), 32'd0);
        chk("rst_sb_valid",    32'(sb_if.valid),  32'd1);
        step();
        rst = 1'b0;
        idle();

        // First store becomes visible at the head one cycle later.
        enq(32'h100, 32'hAAAA);
        step(); idle(); #2;
        chk("first_empty",       32'(empty),       32'd0);
        chk("first_drain_valid", 32'(drain_valid), 32'd1);
        chk("first_drain_addr",  drain_addr,       32'h100);
        chk("first_drain_data",  drain_data,       32'hAAAA);
        drain_ready = 1'b1;
        step(); idle();

        // Two stores to one word: the younger one forwards, byte offset ignored.
        enq(32'h200, 32'h1); step();
        enq(32'h200, 32'h2); step();
        idle(); lu_valid = 1'b1; lu_addr = 32'h202; #2;
        chk("youngest_hit",  32'(sb_if.sb_hit), 32'd1);
        chk("youngest_data", sb_if.data,        32'h2);

        // Steady state at count 2 with simultaneous enqueue and drain.
        for (int i = 0; i < 10; i++) begin
            enq(32'h400 + 32'(i * 4), 32'(i));
            drain_ready = 1'b1;
            step();
        end
        idle(); #2;
        chk("steady_drain_addr", drain_addr,  32'h420);
        chk("steady_full",       32'(full),   32'd0);
        chk("steady_empty",      32'(empty),  32'd0);
        drain_ready = 1'b1;
        step(); step(); idle();

        // Fill to DEPTH; a store presented while full is dropped even with a drain.
        for (int i = 0; i < 4; i++) begin
            enq(32'h500 + 32'(i * 4), 32'h50 + 32'(i));
            step();
        end
        idle(); #2;
        chk("fill_full",      32'(full),      32'd1);
        chk("fill_enq_ready", 32'(enq_ready), 32'd0);
        step();
        enq(32'h510, 32'h99);
        drain_ready = 1'b1;
        step(); idle();
        lu_valid = 1'b1; lu_addr = 32'h510; #2;
        chk("drop_full",       32'(full),        32'd0);
        chk("drop_drain_addr", drain_addr,       32'h504);
        chk("drop_sb_hit",     32'(sb_if.sb_hit), 32'd0);
        drain_ready = 1'b1;
        repeat (3) step();
        idle();

        // A store enqueued this cycle is not yet visible to lookup.
        enq(32'h300, 32'h3);
        lu_valid = 1'b1; lu_addr = 32'h300; #2;
        chk("same_cycle_hit", 32'(sb_if.sb_hit), 32'd0);
        step();
        enq_valid = 1'b0; #2;
        chk("next_cycle_hit",  32'(sb_if.sb_hit), 32'd1);
        chk("next_cycle_data", sb_if.data,        32'h3);
        enq(32'h304, 32'h4); step();
        enq(32'h308, 32'h5); step();
        idle();

        // Reset mid-drain discards everything immediately.
        drain_ready = 1'b1;
        lu_valid    = 1'b1;
        lu_addr     = 32'h304;
        rst         = 1'b1;
        #1;
        chk("midrst_empty",       32'(empty),        32'd1);
        chk("midrst_drain_valid", 32'(drain_valid),  32'd0);
        chk("midrst_sb_hit",      32'(sb_if.sb_hit), 32'd0);
        step();
        rst = 1'b0;
        idle();

        for (int n = 0; n < 3000; n++) begin
            enq_valid   = ($urandom_range(0, 99) < 55);
            enq_addr    = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            enq_data    = $urandom;
            drain_ready = ($urandom_range(0, 99) < 40);
            lu_valid    = ($urandom_range(0, 99) < 70);
            lu_addr     = 32'h1000 + (32'($urandom_range(0, 9)) << 2) + 32'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
